// File: rtl/imem_responder_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rv32_imem_pkg : shared types for the instruction-memory responder        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package rv32_imem_pkg;

  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [BYTE_W-1:0] byte_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } imem_state_t;

endpackage
`default_nettype wire

// File: rtl/imem_byte_array.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | imem_byte_array : byte storage, one byte write port, LE word read        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module imem_byte_array
  import rv32_imem_pkg::*;
#(
  parameter int DEPTH_BYTES = 64,
  parameter int BIDX_W      = $clog2(DEPTH_BYTES)
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [BIDX_W-1:0] wr_idx_i,
  input  byte_t             wr_byte_i,
  input  logic [BIDX_W-1:0] rd_base_i,
  output word_t             rd_word_o
);

  // Contents are deliberately not reset so a program survives rst_n.
  byte_t mem_q [DEPTH_BYTES];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_idx_i] <= wr_byte_i;
    end
  end

  // rd_base_i is word aligned, so OR-ing the lane number forms each byte index.
  always_comb begin
    rd_word_o = {mem_q[rd_base_i | BIDX_W'(3)],
                 mem_q[rd_base_i | BIDX_W'(2)],
                 mem_q[rd_base_i | BIDX_W'(1)],
                 mem_q[rd_base_i]};
  end

endmodule
`default_nettype wire

// File: rtl/imem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | imem_responder : fetch-side memory with valid/ready and wait states      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module imem_responder
  import rv32_imem_pkg::*;
#(
  parameter int DEPTH_BYTES = 64,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  input  logic        ld_en,
  input  logic [31:0] ld_addr,
  input  logic [7:0]  ld_byte
);

  localparam int         BIDX_W    = $clog2(DEPTH_BYTES);
  localparam logic [3:0] WAIT_LD   = 4'(WAIT_CYCLES);
  localparam word_t      DEPTH_W   = word_t'(DEPTH_BYTES);
  localparam word_t      LAST_WORD = word_t'(DEPTH_BYTES - 4);

  imem_state_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  word_t       addr_q, addr_d;
  word_t       data_q, data_d;
  logic        err_q, err_d;

  word_t cap_addr;
  word_t rd_word;
  logic  cap_err;
  logic  ld_hit;

  assign ld_hit   = ld_en && (ld_addr < DEPTH_W);
  // With zero wait states RESP is entered on the accept edge itself.
  assign cap_addr = (state_q == IDLE) ? req_addr : addr_q;
  assign cap_err  = (cap_addr[1:0] != 2'b00) || (cap_addr > LAST_WORD);

  imem_byte_array #(
    .DEPTH_BYTES (DEPTH_BYTES),
    .BIDX_W      (BIDX_W)
  ) u_mem (
    .clk       (clk),
    .wr_en_i   (ld_hit),
    .wr_idx_i  (ld_addr[BIDX_W-1:0]),
    .wr_byte_i (ld_byte),
    .rd_base_i (cap_addr[BIDX_W-1:0]),
    .rd_word_o (rd_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d = req_addr;
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
          end else begin
            cnt_d   = WAIT_LD;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Response registers sample memory only on the edge that enters RESP.
    if ((state_d == RESP) && (state_q != RESP)) begin
      err_d  = cap_err;
      data_d = cap_err ? '0 : rd_word;
    end
  end

  always_comb begin
    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == RESP);
    rsp_data  = data_q;
    rsp_err   = err_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_imem_responder : four responders (0..3 wait states) vs a byte model   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_imem_responder;

  localparam int DEPTH = 64;
  localparam int NDUT  = 4;

  logic             clk;
  logic             rst_n;
  logic [NDUT-1:0]  req_valid;
  logic [NDUT-1:0]  req_ready;
  logic [31:0]      req_addr [NDUT];
  logic [NDUT-1:0]  rsp_valid;
  logic [NDUT-1:0]  rsp_ready;
  logic [31:0]      rsp_data [NDUT];
  logic [NDUT-1:0]  rsp_err;
  logic             ld_en;
  logic [31:0]      ld_addr;
  logic [7:0]       ld_byte;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  logic [7:0] mem_m [DEPTH];

  for (genvar k = 0; k < NDUT; k++) begin : g_dut
    imem_responder #(
      .DEPTH_BYTES (DEPTH),
      .WAIT_CYCLES (k)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid[k]),
      .req_ready (req_ready[k]),
      .req_addr  (req_addr[k]),
      .rsp_valid (rsp_valid[k]),
      .rsp_ready (rsp_ready[k]),
      .rsp_data  (rsp_data[k]),
      .rsp_err   (rsp_err[k]),
      .ld_en     (ld_en),
      .ld_addr   (ld_addr),
      .ld_byte   (ld_byte)
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void ref_read(input logic [31:0] a, output logic [31:0] d, output logic e);
    longint la = longint'(a);
    if ((la % 4) != 0 || la > DEPTH - 4) begin
      e = 1'b1;
      d = 32'h0;
    end else begin
      e = 1'b0;
      d = {mem_m[la+3], mem_m[la+2], mem_m[la+1], mem_m[la]};
    end
  endfunction

  task automatic load_byte(input logic [31:0] a, input logic [7:0] b);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_byte = b;
    @(negedge clk);
    ld_en = 1'b0;
    if (a < DEPTH) mem_m[a] = b;
  endtask

  // Called at a negedge with instance k idle; returns at a negedge, k idle again.
  task automatic do_fetch(input int k, input logic [31:0] a, input int bp, input string name,
                          output logic [31:0] got_d, output logic got_e);
    logic [31:0] ed, hd;
    logic        ee, he;
    int          n;
    ref_read(a, ed, ee);
    req_valid[k] = 1'b1;
    req_addr[k]  = a;
    chk_cnt++;
    if (req_ready[k] !== 1'b1) $display("FAIL %s req_ready_idle got=%b exp=1", name, req_ready[k]);
    else pass_cnt++;
    @(negedge clk);
    req_valid[k] = 1'b0;
    n = 1;
    while (rsp_valid[k] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk_cnt++;
    if (n !== k + 1) $display("FAIL %s latency got=%0d exp=%0d", name, n, k + 1);
    else pass_cnt++;
    got_d = rsp_data[k];
    got_e = rsp_err[k];
    chk_cnt++;
    if (got_d !== ed || got_e !== ee)
      $display("FAIL %s rsp addr=%h got=%h/%b exp=%h/%b", name, a, got_d, got_e, ed, ee);
    else pass_cnt++;
    hd = got_d;
    he = got_e;
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      chk_cnt++;
      if (rsp_valid[k] !== 1'b1 || rsp_data[k] !== hd || rsp_err[k] !== he || req_ready[k] !== 1'b0)
        $display("FAIL %s hold v=%b d=%h e=%b rdy=%b exp v=1 d=%h e=%b rdy=0",
                 name, rsp_valid[k], rsp_data[k], rsp_err[k], req_ready[k], hd, he);
      else pass_cnt++;
    end
    rsp_ready[k] = 1'b1;
    @(negedge clk);
    rsp_ready[k] = 1'b0;
    chk_cnt++;
    if (rsp_valid[k] !== 1'b0 || req_ready[k] !== 1'b1)
      $display("FAIL %s after_hs v=%b rdy=%b exp v=0 rdy=1", name, rsp_valid[k], req_ready[k]);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    for (int k = 0; k < NDUT; k++) begin
      chk_cnt++;
      if (req_ready[k] !== 1'b1 || rsp_valid[k] !== 1'b0 || rsp_data[k] !== 32'h0 || rsp_err[k] !== 1'b0)
        $display("FAIL reset dut%0d rdy=%b v=%b d=%h e=%b exp 1/0/0/0",
                 k, req_ready[k], rsp_valid[k], rsp_data[k], rsp_err[k]);
      else pass_cnt++;
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_load_program();
    for (int i = 0; i < DEPTH; i++) load_byte(32'(i), 8'($urandom));
    load_byte(32'd0, 8'h13);
    load_byte(32'd1, 8'h05);
    load_byte(32'd2, 8'h50);
    load_byte(32'd3, 8'h00);
  endtask

  task automatic test_basic();
    logic [31:0] d;
    logic        e;
    do_fetch(1, 32'd0, 0, "basic", d, e);
    chk_cnt++;
    if (d !== 32'h00500513 || e !== 1'b0) $display("FAIL basic_const got=%h/%b exp=00500513/0", d, e);
    else pass_cnt++;
  endtask

  task automatic test_errors();
    logic [31:0] d;
    logic        e;
    do_fetch(1, 32'd2, 0, "err_misalign", d, e);
    do_fetch(1, 32'd64, 0, "err_oor", d, e);
    chk_cnt++;
    if (d !== 32'h0 || e !== 1'b1) $display("FAIL err_oor_const got=%h/%b exp=0/1", d, e);
    else pass_cnt++;
    do_fetch(1, 32'd60, 0, "last_word", d, e);
    do_fetch(2, 32'hFFFF_FFFC, 0, "err_wrap", d, e);
  endtask

  task automatic test_backpressure();
    logic [31:0] d;
    logic        e;
    do_fetch(1, 32'd4, 3, "bp_w1", d, e);
    do_fetch(2, 32'd5, 3, "bp_w2_err", d, e);
  endtask

  task automatic test_back_to_back(input int k);
    logic [31:0] a, ed;
    logic        ee;
    int          n;
    req_valid[k] = 1'b1;
    rsp_ready[k] = 1'b1;
    for (int r = 0; r < 4; r++) begin
      a = 32'($urandom_range(0, DEPTH / 4 - 1) * 4);
      req_addr[k] = a;
      ref_read(a, ed, ee);
      chk_cnt++;
      if (req_ready[k] !== 1'b1 || rsp_valid[k] !== 1'b0)
        $display("FAIL b2b dut%0d accept rdy=%b v=%b exp 1/0", k, req_ready[k], rsp_valid[k]);
      else pass_cnt++;
      @(negedge clk);
      n = 1;
      while (rsp_valid[k] !== 1'b1 && n < 40) begin
        @(negedge clk);
        n++;
      end
      chk_cnt++;
      if (n !== k + 1 || rsp_data[k] !== ed || rsp_err[k] !== ee)
        $display("FAIL b2b dut%0d lat=%0d d=%h e=%b exp lat=%0d d=%h e=%b",
                 k, n, rsp_data[k], rsp_err[k], k + 1, ed, ee);
      else pass_cnt++;
      @(negedge clk);
    end
    req_valid[k] = 1'b0;
    rsp_ready[k] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_wait_write();
    int n;
    load_byte(32'd8,  8'hEF);
    load_byte(32'd9,  8'hBE);
    load_byte(32'd10, 8'hAD);
    load_byte(32'd11, 8'hDE);
    req_valid[2] = 1'b1;
    req_addr[2]  = 32'd8;
    @(negedge clk);
    req_valid[2] = 1'b0;
    load_byte(32'd8, 8'h00);
    n = 2;
    while (rsp_valid[2] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk_cnt++;
    if (n !== 3 || rsp_data[2] !== 32'hDEADBE00 || rsp_err[2] !== 1'b0)
      $display("FAIL wait_write lat=%0d d=%h e=%b exp lat=3 d=deadbe00 e=0", n, rsp_data[2], rsp_err[2]);
    else pass_cnt++;
    rsp_ready[2] = 1'b1;
    @(negedge clk);
    rsp_ready[2] = 1'b0;
  endtask

  task automatic test_same_edge_write();
    load_byte(32'd12, 8'h11);
    load_byte(32'd13, 8'h22);
    load_byte(32'd14, 8'h33);
    load_byte(32'd15, 8'h44);
    req_valid[1] = 1'b1;
    req_addr[1]  = 32'd12;
    @(negedge clk);
    req_valid[1] = 1'b0;
    load_byte(32'd12, 8'h99);
    chk_cnt++;
    if (rsp_valid[1] !== 1'b1 || rsp_data[1] !== 32'h44332211)
      $display("FAIL same_edge_write v=%b d=%h exp v=1 d=44332211", rsp_valid[1], rsp_data[1]);
    else pass_cnt++;
    rsp_ready[1] = 1'b1;
    @(negedge clk);
    rsp_ready[1] = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] d;
    logic        e;
    req_valid[3] = 1'b1;
    req_addr[3]  = 32'd0;
    @(negedge clk);
    req_valid[3] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_cnt++;
    if (req_ready[3] !== 1'b1 || rsp_valid[3] !== 1'b0)
      $display("FAIL rst_async rdy=%b v=%b exp 1/0", req_ready[3], rsp_valid[3]);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk_cnt++;
      if (rsp_valid !== '0 || req_ready !== '1)
        $display("FAIL rst_stale cyc%0d v=%b rdy=%b exp v=0000 rdy=1111", i, rsp_valid, req_ready);
      else pass_cnt++;
    end
    do_fetch(3, 32'd0, 0, "refetch", d, e);
    chk_cnt++;
    if (d !== 32'h00500513) $display("FAIL refetch_const got=%h exp=00500513", d);
    else pass_cnt++;
  endtask

  task automatic test_oor_load();
    logic [31:0] d;
    logic        e;
    load_byte(32'd64, 8'hAA);
    load_byte(32'd67, 8'hBB);
    load_byte(32'h8000_0001, 8'hCC);
    do_fetch(0, 32'd0, 0, "oor_load", d, e);
    chk_cnt++;
    if (d !== 32'h00500513) $display("FAIL oor_load_const got=%h exp=00500513", d);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [31:0] a, d;
    logic        e;
    int          k;
    for (int it = 0; it < 30; it++) begin
      for (int j = 0; j < 2; j++) begin
        if ($urandom_range(0, 3) == 0) load_byte(32'($urandom_range(DEPTH, 4 * DEPTH)), 8'($urandom));
        else load_byte(32'($urandom_range(0, DEPTH - 1)), 8'($urandom));
      end
      case ($urandom_range(0, 3))
        0, 1: a = 32'($urandom_range(0, DEPTH / 4 - 1) * 4);
        2:    a = 32'($urandom_range(0, DEPTH + 8));
        default: a = $urandom;
      endcase
      k = int'($urandom_range(0, NDUT - 1));
      do_fetch(k, a, int'($urandom_range(0, 3)), "random", d, e);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = '0;
    for (int k = 0; k < NDUT; k++) req_addr[k] = '0;
    ld_en   = 1'b0;
    ld_addr = '0;
    ld_byte = '0;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 8'h00;
    test_reset();
    test_load_program();
    test_basic();
    test_errors();
    test_backpressure();
    test_back_to_back(0);
    test_back_to_back(3);
    test_wait_write();
    test_same_edge_write();
    test_reset_mid_wait();
    test_oor_load();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
`default_nettype wire
